// File: rtl/dbus_arb.sv
// Data-bus arbiter: CPU memory stage vs DMA onto one slave bus, one access at a time.
// Define DBUS_STARVE_EN to build the DMA anti-starvation counter; otherwise the CPU has strict priority.
module dbus_arb #(
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        flush,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, CPU, DMA} state_t;

    state_t state;
    logic   cpu_done;
    logic   dma_done;
    logic   cpu_pend;
    logic   cpu_elig;
    logic   dma_elig;
    logic   starve;
    logic   grant_cpu;
    logic   grant_dma;

    // A CPU request blocked only by its own done cycle still outranks the DMA.
    assign cpu_pend  = cpu_req & ~flush;
    assign cpu_elig  = cpu_pend & ~cpu_done;
    assign dma_elig  = dma_req & ~dma_done;
    assign grant_dma = (state == IDLE) & dma_elig & (~cpu_pend | starve);
    assign grant_cpu = (state == IDLE) & cpu_elig & ~grant_dma;

    assign cpu_stall = cpu_req & ~cpu_done & ~flush;
    assign dma_gnt   = dma_done;

`ifdef DBUS_STARVE_EN
    localparam int CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign starve = dma_req & (starve_cnt == CNT_W'(STARVE_LIM));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant_dma) begin
            starve_cnt <= '0;
        end else if (grant_cpu && dma_req && (starve_cnt != CNT_W'(STARVE_LIM))) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    assign starve = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            cpu_rdata <= 32'h0;
            dma_rdata <= 32'h0;
            cpu_done  <= 1'b0;
            dma_done  <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            dma_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_cpu) begin
                        mem_req   <= 1'b1;
                        mem_we    <= cpu_we;
                        mem_be    <= cpu_be;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        state     <= CPU;
                    end else if (grant_dma) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dma_we;
                        mem_be    <= 4'b1111;
                        mem_addr  <= dma_addr;
                        mem_wdata <= dma_wdata;
                        state     <= DMA;
                    end
                end
                CPU: begin
                    // Completes even under flush; the data is simply not consumed.
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        cpu_rdata <= mem_rdata;
                        cpu_done  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DMA: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        dma_rdata <= mem_rdata;
                        dma_done  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_arb.sv
// Directed bench for dbus_arb: reset, load, store, arbitration, flush and mid-access reset.
module tb_dbus_arb;

    localparam logic [31:0] DMA_ADDR = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, flush = 1'b0;
    logic [3:0]  cpu_be = 4'h0;
    logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = 32'h0, dma_wdata = 32'h0;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dbus_arb #(.STARVE_LIM(4)) dut (
        .clk(clk), .reset(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .flush(flush), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // Slave responder: acks slv_wait cycles after mem_req rises, or follows force_ack when disabled.
    logic        slv_en = 1'b0;
    logic        force_ack = 1'b0;
    int          slv_wait = 0;
    int          slv_cnt = 0;
    logic [31:0] slv_rdata = 32'h0;

    always @(negedge clk) begin
        if (!slv_en) begin
            mem_ack = force_ack;
            slv_cnt = 0;
        end else if (mem_req && !mem_ack) begin
            slv_cnt = slv_cnt + 1;
            mem_ack = (slv_cnt > slv_wait);
        end else begin
            mem_ack = 1'b0;
            slv_cnt = 0;
        end
        mem_rdata = slv_rdata;
    end

    // Bus monitor: counts transactions, records owner (1 = DMA) of each, counts dma_gnt pulses.
    int   n_txn = 0;
    int   n_gnt = 0;
    logic req_q = 1'b0;
    bit   owner_q[$];

    always @(negedge clk) begin
        if (mem_req && !req_q) begin
            n_txn = n_txn + 1;
            owner_q.push_back(mem_addr == DMA_ADDR);
        end
        if (dma_gnt) n_gnt = n_gnt + 1;
        req_q = mem_req;
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 70'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got req=%b we=%b be=%h addr=%h wdata=%h want all 0",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        n_tests++;
        if ({cpu_rdata, dma_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got cpu=%h dma=%h want 0", cpu_rdata, dma_rdata);
        end
        n_tests++;
        if ({dma_gnt, cpu_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: got gnt=%b stall=%b want 00", dma_gnt, cpu_stall);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_req: got %b want 0", mem_req);
        end
    endtask

    task automatic test_cpu_load();
        int stall_cycles;
        int t0;
        slv_en = 1'b1; slv_wait = 2; slv_rdata = 32'hDEAD_BEEF;
        t0 = n_txn;
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = 32'h0000_0010; cpu_wdata = 32'h0;
        #1;
        stall_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (!cpu_stall) break;
            stall_cycles++;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (stall_cycles !== 4) begin
            n_fail++;
            $display("FAIL load_stall_cycles: got %0d want 4", stall_cycles);
        end
        n_tests++;
        if (cpu_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL load_rdata: got %h want deadbeef", cpu_rdata);
        end
        cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (n_txn - t0 !== 1) begin
            n_fail++;
            $display("FAIL load_txn_count: got %0d want 1", n_txn - t0);
        end
    endtask

    task automatic test_cpu_store();
        int hold;
        slv_en = 1'b1; slv_wait = 3;
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'b0011; cpu_addr = 32'h0000_0020; cpu_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        n_tests++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL store_grant_latency: got mem_req=%b want 1", mem_req);
        end
        hold = 0;
        for (int i = 0; i < 20; i++) begin
            if (!mem_req) break;
            hold++;
            n_tests++;
            if ({mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 4'b0011, 32'h0000_0020, 32'h1234_5678}) begin
                n_fail++;
                $display("FAIL store_bus_stable: got we=%b be=%b addr=%h wdata=%h want 1 0011 00000020 12345678",
                         mem_we, mem_be, mem_addr, mem_wdata);
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (hold !== 4) begin
            n_fail++;
            $display("FAIL store_req_cycles: got %0d want 4", hold);
        end
        n_tests++;
        if (cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL store_done_stall: got %b want 0", cpu_stall);
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_arbitration();
        int   g0;
        logic got;
        logic want;
        slv_en = 1'b1; slv_wait = 0; slv_rdata = 32'h0000_A5A5;
        owner_q.delete();
        g0 = n_gnt;
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = 32'h0000_0100;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = DMA_ADDR;
        for (int c = 0; c < 200; c++) begin
            if (owner_q.size() >= 10) break;
            @(posedge clk);
            #1;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
`ifdef DBUS_STARVE_EN
            want = ((i % 5) == 4);
`else
            want = 1'b0;
`endif
            got = (i < owner_q.size()) ? logic'(owner_q[i]) : 1'bx;
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL arb_grant_%0d: got owner %b want %b (1=DMA)", i, got, want);
            end
        end
        n_tests++;
`ifdef DBUS_STARVE_EN
        if (n_gnt - g0 !== 2) begin
            n_fail++;
            $display("FAIL arb_dma_gnt_pulses: got %0d want 2", n_gnt - g0);
        end
`else
        if (n_gnt - g0 !== 0) begin
            n_fail++;
            $display("FAIL arb_dma_gnt_pulses: got %0d want 0", n_gnt - g0);
        end
`endif
    endtask

    task automatic test_flush();
        int t0;
        slv_en = 1'b1; slv_wait = 3; slv_rdata = 32'hCAFE_F00D;
        t0 = n_txn;
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = 32'h0000_0030;
        @(posedge clk);
        #1;
        n_tests++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_grant: got mem_req=%b want 1", mem_req);
        end
        flush = 1'b1;
        #1;
        n_tests++;
        if (cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall_first: got %b want 0", cpu_stall);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (cpu_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_stall_cycle%0d: got %b want 0", i, cpu_stall);
            end
        end
        n_tests++;
        if (n_txn - t0 !== 1) begin
            n_fail++;
            $display("FAIL flush_txn_count: got %0d want 1", n_txn - t0);
        end
        n_tests++;
        if (cpu_rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL flush_rdata: got %h want cafef00d", cpu_rdata);
        end
        flush = 1'b0; cpu_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        slv_en = 1'b1; slv_wait = 10; slv_rdata = 32'h1111_2222;
        @(posedge clk);
        #1;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = DMA_ADDR; dma_wdata = 32'h7777_8888;
        @(posedge clk);
        #1;
        n_tests++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_grant: got mem_req=%b want 1", mem_req);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 70'h0) begin
            n_fail++;
            $display("FAIL rstmid_bus_async: got req=%b we=%b be=%h addr=%h wdata=%h want all 0",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        n_tests++;
        if ({cpu_rdata, dma_rdata, dma_gnt, cpu_stall} !== 66'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got cpu=%h dma=%h gnt=%b stall=%b want 0",
                     cpu_rdata, dma_rdata, dma_gnt, cpu_stall);
        end
        dma_req = 1'b0; dma_we = 1'b0;
        slv_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        slv_rdata = 32'h0000_0055;
        @(posedge clk);
        #1;
        force_ack = 1'b1;
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({mem_req, dma_gnt, dma_rdata, cpu_rdata} !== 66'h0) begin
            n_fail++;
            $display("FAIL rstmid_stray_ack: got req=%b gnt=%b dma=%h cpu=%h want 0",
                     mem_req, dma_gnt, dma_rdata, cpu_rdata);
        end
        slv_en = 1'b1; slv_wait = 1; slv_rdata = 32'h0BAD_F00D;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = 32'h0000_0040;
        @(posedge clk);
        #1;
        n_tests++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0040}) begin
            n_fail++;
            $display("FAIL rstmid_regrant: got req=%b addr=%h want 1 00000040", mem_req, mem_addr);
        end
        for (int i = 0; i < 20; i++) begin
            if (!cpu_stall) break;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if ({cpu_stall, cpu_rdata} !== {1'b0, 32'h0BAD_F00D}) begin
            n_fail++;
            $display("FAIL rstmid_regrant_data: got stall=%b rdata=%h want 0 0badf00d", cpu_stall, cpu_rdata);
        end
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_cpu_load();
        test_cpu_store();
        test_arbitration();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
